// File: rtl/timer_pkg.sv
// timer_pkg: register addresses, bit positions and APB phase states shared by the timer register interface.
package timer_pkg;
    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;
    localparam int TCR_LOAD   = 7;
    localparam int TCR_DOWN   = 5;
    localparam int TCR_EN     = 4;
    localparam int TCR_CKS_HI = 1;
    localparam int TCR_CKS_LO = 0;
    localparam int TSR_OVF    = 0;
    localparam int TSR_UDF    = 1;
    localparam logic [7:0] TCR_MASK = 8'hB3;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
endpackage

// File: rtl/apb_slave_fsm.sv
// apb_slave_fsm: APB phase tracking, wait-state counter and registered pready/pslverr with read/write strobes.
module apb_slave_fsm
    import timer_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic pclk,
    input  logic presetn,
    input  logic psel,
    input  logic penable,
    input  logic pwrite,
    input  logic err_i,
    output logic pready,
    output logic pslverr,
    output logic wr_en_o,
    output logic rd_en_o
);
    localparam int CW = 3;
    apb_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic pready_q, pready_d, pslverr_q, pslverr_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    if (psel && !penable) state_d = SETUP;
            SETUP: begin
                if (!psel) state_d = IDLE;
                else if (penable) begin
                    state_d = ACCESS;
                    cnt_d   = CW'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!psel) state_d = IDLE;
                else if (cnt_q == '0) state_d = penable ? IDLE : SETUP;
                else cnt_d = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
        // pready is registered, so it is raised on the edge entering the zero-count ACCESS cycle
        pready_d  = (state_d == ACCESS) && (cnt_d == '0);
        pslverr_d = pready_d && err_i;
    end
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end
    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign rd_en_o = pready_d && !pwrite;
    assign wr_en_o = pready_q && pwrite && !pslverr_q;
endmodule

// File: rtl/timer_apb_regif.sv
// timer_apb_regif: APB register file of the 8-bit timer holding TDR, TCR and sticky TSR, with live TCNT readback.
module timer_apb_regif
    import timer_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [7:0]        tcnt_i,
    input  logic              ovf_set_i,
    input  logic              udf_set_i,
    output logic [7:0]        tdr_o,
    output logic              load_o,
    output logic              down_o,
    output logic              en_o,
    output logic [1:0]        cks_o
);
    logic [7:0] tdr_q, tdr_d, tcr_q, tcr_d, prdata_q, prdata_d, rdata, wdata;
    logic [1:0] tsr_q, tsr_d, tsr_set;
    logic wr_en, rd_en, err, a_tdr, a_tcr, a_tsr, a_tcnt;
    apb_slave_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .err_i   (err),
        .pready  (pready),
        .pslverr (pslverr),
        .wr_en_o (wr_en),
        .rd_en_o (rd_en)
    );
    assign wdata  = pwdata[7:0];
    assign a_tdr  = paddr == ADDR_W'(ADDR_TDR);
    assign a_tcr  = paddr == ADDR_W'(ADDR_TCR);
    assign a_tsr  = paddr == ADDR_W'(ADDR_TSR);
    assign a_tcnt = paddr == ADDR_W'(ADDR_TCNT);
    assign err    = !(a_tdr || a_tcr || a_tsr || a_tcnt) || (pwrite && a_tcnt);
    always_comb begin
        tsr_set          = '0;
        tsr_set[TSR_OVF] = ovf_set_i;
        tsr_set[TSR_UDF] = udf_set_i;
        rdata    = a_tdr ? tdr_q : a_tcr ? tcr_q : a_tsr ? {6'b0, tsr_q} : a_tcnt ? tcnt_i : 8'h00;
        tdr_d    = (wr_en && a_tdr) ? wdata : tdr_q;
        tcr_d    = (wr_en && a_tcr) ? (wdata & TCR_MASK) : tcr_q;
        // hardware set is OR-ed after the write-0-to-clear so a same-cycle event is never lost
        tsr_d    = ((wr_en && a_tsr) ? (tsr_q & wdata[1:0]) : tsr_q) | tsr_set;
        prdata_d = rd_en ? rdata : prdata_q;
    end
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr_q    <= 8'h00;
            tcr_q    <= 8'h00;
            tsr_q    <= 2'b00;
            prdata_q <= 8'h00;
        end else begin
            tdr_q    <= tdr_d;
            tcr_q    <= tcr_d;
            tsr_q    <= tsr_d;
            prdata_q <= prdata_d;
        end
    end
    assign prdata = DATA_W'(prdata_q);
    assign tdr_o  = tdr_q;
    assign load_o = tcr_q[TCR_LOAD];
    assign down_o = tcr_q[TCR_DOWN];
    assign en_o   = tcr_q[TCR_EN];
    assign cks_o  = tcr_q[TCR_CKS_HI:TCR_CKS_LO];
endmodule

// File: tb/tb_timer_apb_regif.sv
// tb_timer_apb_regif: randomized APB traffic against a transaction-level register model, compared every cycle.
module tb_timer_apb_regif;
    localparam int WS = 3;
    logic pclk = 1'b0, presetn = 1'b0, psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0] paddr = 8'h00, pwdata = 8'h00, tcnt_i = 8'h00;
    logic ovf_set_i = 1'b0, udf_set_i = 1'b0;
    logic [7:0] prdata, tdr_o;
    logic pready, pslverr, load_o, down_o, en_o;
    logic [1:0] cks_o;
    int n_chk = 0, n_fail = 0;
    int last_lat, last_err;
    bit rnd_en = 1'b0;
    logic [7:0] m_tdr = 8'h00, m_tcr = 8'h00, m_prdata = 8'h00;
    logic [1:0] m_tsr = 2'b00;
    logic m_pready = 1'b0, m_pslverr = 1'b0;

    always #5 pclk = ~pclk;

    timer_apb_regif #(.WAIT_STATES(WS), .ADDR_W(8), .DATA_W(8)) dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .tcnt_i(tcnt_i), .ovf_set_i(ovf_set_i), .udf_set_i(udf_set_i), .tdr_o(tdr_o),
        .load_o(load_o), .down_o(down_o), .en_o(en_o), .cks_o(cks_o)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("pready", 8'(pready), 8'(m_pready));
        chk("pslverr", 8'(pslverr), 8'(m_pslverr));
        chk("prdata", prdata, m_prdata);
        chk("tdr_o", tdr_o, m_tdr);
        chk("load_o", 8'(load_o), 8'(m_tcr[7]));
        chk("down_o", 8'(down_o), 8'(m_tcr[5]));
        chk("en_o", 8'(en_o), 8'(m_tcr[4]));
        chk("cks_o", 8'(cks_o), 8'(m_tcr[1:0]));
    endtask

    task automatic model_reset();
        m_tdr = 8'h00; m_tcr = 8'h00; m_tsr = 2'b00; m_prdata = 8'h00;
        m_pready = 1'b0; m_pslverr = 1'b0;
    endtask

    function automatic logic [7:0] rd_model(input logic [7:0] a);
        return a == 8'h00 ? m_tdr : a == 8'h01 ? m_tcr : a == 8'h02 ? {6'b0, m_tsr} : tcnt_i;
    endfunction

    // done: this edge starts the cycle that must show pready; commit: this edge ends it
    task automatic step(input bit done, input bit commit);
        bit err;
        err = (paddr > 8'h03) || (pwrite && paddr == 8'h03);
        if (done && !pwrite) m_prdata = err ? 8'h00 : rd_model(paddr);
        if (commit && pwrite && !err) begin
            if (paddr == 8'h00) m_tdr = pwdata;
            if (paddr == 8'h01) m_tcr = pwdata & 8'hB3;
            if (paddr == 8'h02) m_tsr = m_tsr & pwdata[1:0];
        end
        m_tsr = m_tsr | {udf_set_i, ovf_set_i};
        m_pready = done;
        m_pslverr = done && err;
        @(negedge pclk);
        compare();
        if (rnd_en) begin
            tcnt_i = 8'($urandom);
            ovf_set_i = ($urandom_range(0, 7) == 0);
            udf_set_i = ($urandom_range(0, 7) == 0);
        end else begin
            ovf_set_i = 1'b0;
            udf_set_i = 1'b0;
        end
    endtask

    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                        input int abort_at = -1, input bit ovf_cc = 1'b0);
        last_lat = 0;
        last_err = 0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        step(1'b0, 1'b0);
        penable = 1'b1;
        for (int k = 1; k <= WS + 2; k++) begin
            if (k - 1 == abort_at) begin
                psel = 1'b0; penable = 1'b0;
                step(1'b0, 1'b0);
                return;
            end
            if (ovf_cc && k == WS + 2) ovf_set_i = 1'b1;
            step(k == WS + 1, k == WS + 2);
            if (pready && last_lat == 0) last_lat = k;
            if (pslverr) last_err = 1;
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        logic [7:0] ra;
        repeat (2) @(negedge pclk);
        compare();
        presetn = 1'b1;
        tcnt_i = 8'h5A;
        xfer(1'b0, 8'h00, 8'h00); chk("rst_tdr", prdata, 8'h00); chk("rst_lat", 8'(last_lat), 8'd4);
        chk("rst_err", 8'(last_err), 8'd0);
        xfer(1'b0, 8'h01, 8'h00); chk("rst_tcr", prdata, 8'h00);
        xfer(1'b0, 8'h02, 8'h00); chk("rst_tsr", prdata, 8'h00);
        xfer(1'b0, 8'h03, 8'h00); chk("rst_tcnt", prdata, 8'h5A);
        xfer(1'b1, 8'h01, 8'h10); chk("en_after_wr", 8'(en_o), 8'd1);
        xfer(1'b0, 8'h01, 8'h00); chk("tcr_rd", prdata, 8'h10);
        xfer(1'b1, 8'h01, 8'hFF);
        xfer(1'b0, 8'h01, 8'h00); chk("tcr_mask", prdata, 8'hB3);
        xfer(1'b1, 8'h00, 8'hFA);
        xfer(1'b1, 8'h01, 8'h80); chk("load_hi", 8'(load_o), 8'd1);
        xfer(1'b1, 8'h01, 8'h10); chk("load_lo", 8'(load_o), 8'd0); chk("tdr_fa", tdr_o, 8'hFA);
        ovf_set_i = 1'b1;
        step(1'b0, 1'b0);
        xfer(1'b0, 8'h02, 8'h00); chk("tsr_ovf", prdata, 8'h01);
        xfer(1'b1, 8'h02, 8'h00);
        xfer(1'b0, 8'h02, 8'h00); chk("tsr_clr", prdata, 8'h00);
        xfer(1'b1, 8'h02, 8'h00, -1, 1'b1);
        xfer(1'b0, 8'h02, 8'h00); chk("tsr_set_wins", prdata, 8'h01);
        xfer(1'b1, 8'h02, 8'h00);
        xfer(1'b1, 8'h03, 8'h55); chk("err_wr_tcnt", 8'(last_err), 8'd1);
        xfer(1'b1, 8'h10, 8'h55); chk("err_wr_inv", 8'(last_err), 8'd1);
        xfer(1'b0, 8'h10, 8'h00); chk("err_rd_inv", 8'(last_err), 8'd1); chk("err_rd_data", prdata, 8'h00);
        xfer(1'b0, 8'h00, 8'h00); chk("tdr_kept", prdata, 8'hFA);
        xfer(1'b1, 8'h00, 8'h33, 2);
        xfer(1'b0, 8'h00, 8'h00); chk("abort_nowr", prdata, 8'hFA);
        rnd_en = 1'b1;
        repeat (200) begin
            ra = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            xfer(1'($urandom_range(0, 1)), ra, 8'($urandom),
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, WS)) : -1);
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
        end
        rnd_en = 1'b0;
        ovf_set_i = 1'b0; udf_set_i = 1'b0;
        xfer(1'b1, 8'h00, 8'hC3);
        xfer(1'b1, 8'h01, 8'hB1);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h77;
        step(1'b0, 1'b0);
        penable = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        #2 presetn = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        model_reset();
        #1 compare();
        #39 presetn = 1'b1;
        @(negedge pclk);
        compare();
        tcnt_i = 8'hC4;
        xfer(1'b0, 8'h00, 8'h00); chk("mid_rst_tdr", prdata, 8'h00);
        xfer(1'b0, 8'h01, 8'h00); chk("mid_rst_tcr", prdata, 8'h00);
        xfer(1'b0, 8'h02, 8'h00); chk("mid_rst_tsr", prdata, 8'h00);
        xfer(1'b0, 8'h03, 8'h00); chk("mid_rst_tcnt", prdata, 8'hC4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_apb_regif.md
Name: timer_apb_regif

Overview:
- APB responder and register file of the 8-bit timer IP; the CPU bus model is the initiator on the other end.
- Decodes APB setup/access phases with optional wait states.
- Holds TDR, TCR and TSR; returns the live counter as TCNT.
- Drives the control fields into the timer counter core and captures its overflow/underflow set pulses into sticky status bits.

Parameters:
- WAIT_STATES, 0: extra access-phase cycles before pready is asserted (0..7).
- ADDR_W, 8: paddr width.
- DATA_W, 8: pwdata/prdata width; registers are fixed at 8 bits.

Ports:
- pclk  in  1  system clock.
- presetn  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDR_W  register address.
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  read data, valid when pready=1.
- pready  out  1  transfer complete.
- pslverr  out  1  error response, valid with pready.
- tcnt_i  in  8  live counter value from the core.
- ovf_set_i  in  1  one-cycle overflow pulse from the core.
- udf_set_i  in  1  one-cycle underflow pulse from the core.
- tdr_o  out  8  reload value.
- load_o  out  1  TCR[7], load TDR into the counter.
- down_o  out  1  TCR[5], 0=count up, 1=count down.
- en_o  out  1  TCR[4], count enable.
- cks_o  out  2  TCR[1:0] clock select: 00=clk/2, 01=clk/4, 10=clk/8, 11=clk/16.

Behaviour:
- Reset (presetn low, asynchronous):
  - TDR=TCR=TSR=0x00, prdata=0x00, pready=0, pslverr=0.
  - FSM returns to IDLE and the wait counter clears.
  - Assertion mid-transfer aborts the transfer; no register changes.
- Address map:
  - 0x00 TDR: RW.
  - 0x01 TCR: RW; bits 6, 3, 2 are reserved, read 0, writes ignored.
  - 0x02 TSR: bit0 OVF, bit1 UDF, others read 0.
  - 0x03 TCNT: RO, returns tcnt_i.
  - Any other address is invalid.
- FSM states:
  - IDLE -> SETUP on psel=1, penable=0.
  - SETUP -> ACCESS on the next cycle if psel=1 and penable=1.
  - SETUP -> IDLE if psel=0.
  - ACCESS: wait counter loads WAIT_STATES on entry and decrements each cycle. pready=1 in the cycle the counter is 0; then -> IDLE, or -> SETUP if psel stays high with penable=0 (back-to-back transfer).
  - psel dropping in ACCESS before pready -> IDLE; the transfer is aborted with no side effect.
  - With WAIT_STATES=0, pready is high in the first ACCESS cycle (zero-wait APB).
- pready and pslverr are registered pulses lasting exactly one cycle per transfer; both are 0 outside the completing cycle.
- Writes:
  - Committed on the rising edge where pready=1 and pwrite=1.
  - TSR write: each status bit is cleared where the pwdata bit is 0 and kept where it is 1 (W0C). Writing 0x00 clears all.
  - Write to TCNT or to an invalid address: pslverr=1, no state change.
- Reads:
  - prdata is loaded in the completing cycle with the addressed register, sampled at that cycle.
  - Invalid address: prdata=0x00, pslverr=1.
  - prdata holds its value until the next read completes.
- Status capture:
  - ovf_set_i=1 sets TSR[0]; udf_set_i=1 sets TSR[1].
  - When a hardware set and a W0C clear hit the same bit in the same cycle, the set wins.
- load_o is a level: it stays 1 until software writes TCR with bit7=0. The core handles the edge.
- Outputs tdr_o, load_o, down_o, en_o and cks_o are direct register bits with no extra latency; a new value is visible the cycle after the write commits.

Decomposition:
- Shared package timer_pkg holds:
  - Address constants ADDR_TDR=0x00, ADDR_TCR=0x01, ADDR_TSR=0x02, ADDR_TCNT=0x03.
  - TCR bit indices (LOAD=7, DOWN=5, EN=4, CKS=1:0) and TSR bit indices (OVF=0, UDF=1).
  - APB FSM state enum {IDLE, SETUP, ACCESS}.
- One sub-module is natural: apb_slave_fsm (phase tracking, wait counter, pready/pslverr timing, write-strobe/read-strobe outputs). The register file stays in the top module.

Test Plan:
- Reset: after reset, read 0x00..0x03 -> 0x00, 0x00, 0x00, tcnt_i. Each read completes with pready for one cycle and pslverr=0.
- Write 0x01 <= 0x10 -> en_o=1, down_o=0, cks_o=00 one cycle after pready. A read of 0x01 returns 0x10. Writing 0xFF to 0x01 then reading returns 0xB3.
- Write TDR 0xFA, then TCR 0x80, then TCR 0x10 -> tdr_o=0xFA, load_o pulses high between the two TCR writes. Pulse ovf_set_i -> read 0x02 = 0x01. Write 0x02 <= 0x00, then read 0x02 = 0x00.
- Same-cycle collision: drive ovf_set_i=1 in the cycle a write of 0x00 to TSR completes -> TSR[0] stays 1 (set wins).
- Error response: write to 0x03 and to 0x10 -> pslverr=1 with pready, registers unchanged. Read 0x10 -> prdata=0x00, pslverr=1.
- WAIT_STATES=3: pready rises exactly 4 cycles after penable. psel dropped after 2 ACCESS cycles -> no write, FSM in IDLE. presetn pulsed low for 40 ns mid-access -> all registers return to 0x00.
